// File: rtl/key_debounce_ctrl.sv
// key_debounce_ctrl
// Multi-channel push-button debouncer and press classifier. Raw key pins pass
// through a two-flop synchroniser every clock and are sampled only on the
// iCke tick. Each channel runs its own debounce FSM and produces a debounced
// level plus registered one-cycle press, release, long-press and repeat pulses.
// Build option: define KEY_AUTO_REPEAT_EN to build the per-channel auto-repeat
// counter behind oRepeat; without it oRepeat is tied low.
module key_debounce_ctrl #(
  parameter int pChNum     = 4,
  parameter int pActiveLow = 1,
  parameter int pStableCnt = 4,
  parameter int pLongCnt   = 500,
  parameter int pRepeatCnt = 100
) (
  input  logic              iSysClk,
  input  logic              iSysRst,
  input  logic              iCke,
  input  logic [pChNum-1:0] iKey,
  output logic [pChNum-1:0] oLevel,
  output logic [pChNum-1:0] oPress,
  output logic [pChNum-1:0] oRelease,
  output logic [pChNum-1:0] oLong,
  output logic [pChNum-1:0] oRepeat
);

  localparam int cScW = $clog2(pStableCnt + 1);
  localparam int cHcW = $clog2(pLongCnt + 1);
  localparam logic [cScW-1:0]   cScLast  = cScW'(pStableCnt - 1);
  localparam logic [cHcW-1:0]   cHcLong  = cHcW'(pLongCnt);
  localparam logic [pChNum-1:0] cIdlePin = (pActiveLow != 0) ? '1 : '0;

  typedef enum logic [2:0] {
    sIdle,
    sPChk,
    sPressed,
    sLong,
    sRChk
  } tKeyState;

  // Reject parameter sets the counters and FSM are not built for.
  if (pChNum < 1 || pChNum > 16 || pStableCnt < 1 || pLongCnt <= pStableCnt ||
      pRepeatCnt < 1) begin : gBadParam
    $error("key_debounce_ctrl: illegal parameter set");
  end

  logic [pChNum-1:0] syncQ0;
  logic [pChNum-1:0] syncQ1;
  logic [pChNum-1:0] keyPressed;

  // Two-flop synchroniser, clocked every cycle; resets to the released pin level.
  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      syncQ0 <= cIdlePin;
      syncQ1 <= cIdlePin;
    end else begin
      syncQ0 <= iKey;
      syncQ1 <= syncQ0;
    end
  end

  // 1 = pressed, whatever the pin polarity.
  assign keyPressed = syncQ1 ^ cIdlePin;

  for (genvar gCh = 0; gCh < pChNum; gCh++) begin : gChan
    tKeyState        stateQ, stateD;
    logic [cScW-1:0] scQ, scD;
    logic [cHcW-1:0] hcQ, hcD;
    logic            levelQ, levelD;
    logic            pressQ, pressD;
    logic            releaseQ, releaseD;
    logic            longQ, longD;
    logic            p;

    assign p = keyPressed[gCh];

    // Debounce FSM next state; everything moves only on a tick.
    // NOTE: every variable gets its default before the case, so no path can
    // leave one unassigned and infer a latch; pulses default to 0 and self-clear.
    always_comb begin
      stateD   = stateQ;
      scD      = scQ;
      hcD      = hcQ;
      levelD   = levelQ;
      pressD   = 1'b0;
      releaseD = 1'b0;
      longD    = 1'b0;
      if (iCke) begin
        unique case (stateQ)
          sIdle: begin
            if (p) begin
              if (pStableCnt == 1) begin
                stateD = sPressed;
                levelD = 1'b1;
                pressD = 1'b1;
                hcD    = '0;
              end else begin
                stateD = sPChk;
                scD    = cScW'(1);
              end
            end
          end
          sPChk: begin
            if (!p) begin
              stateD = sIdle;
              scD    = '0;
            end else if (scQ == cScLast) begin
              stateD = sPressed;
              levelD = 1'b1;
              pressD = 1'b1;
              hcD    = '0;
              scD    = '0;
            end else begin
              scD = scQ + 1'b1;
            end
          end
          sPressed, sLong: begin
            if (p) begin
              // hc saturates at pLongCnt once LONG is reached.
              if (stateQ == sPressed) begin
                hcD = hcQ + 1'b1;
                if (hcD == cHcLong) begin
                  stateD = sLong;
                  longD  = 1'b1;
                end
              end
            end else if (pStableCnt == 1) begin
              stateD   = sIdle;
              levelD   = 1'b0;
              releaseD = 1'b1;
              hcD      = '0;
            end else begin
              stateD = sRChk;
              scD    = cScW'(1);
            end
          end
          sRChk: begin
            if (p) begin
              // hc is frozen here, so hc==pLongCnt identifies a LONG origin.
              stateD = (hcQ == cHcLong) ? sLong : sPressed;
              scD    = '0;
            end else if (scQ == cScLast) begin
              stateD   = sIdle;
              levelD   = 1'b0;
              releaseD = 1'b1;
              hcD      = '0;
              scD      = '0;
            end else begin
              scD = scQ + 1'b1;
            end
          end
          default: stateD = sIdle;
        endcase
      end
    end

    // Channel state, counters, level and pulse registers.
    always_ff @(posedge iSysClk or negedge iSysRst) begin
      if (!iSysRst) begin
        stateQ   <= sIdle;
        scQ      <= '0;
        hcQ      <= '0;
        levelQ   <= 1'b0;
        pressQ   <= 1'b0;
        releaseQ <= 1'b0;
        longQ    <= 1'b0;
      end else begin
        stateQ   <= stateD;
        scQ      <= scD;
        hcQ      <= hcD;
        levelQ   <= levelD;
        pressQ   <= pressD;
        releaseQ <= releaseD;
        longQ    <= longD;
      end
    end

    assign oLevel[gCh]   = levelQ;
    assign oPress[gCh]   = pressQ;
    assign oRelease[gCh] = releaseQ;
    assign oLong[gCh]    = longQ;

`ifdef KEY_AUTO_REPEAT_EN
    localparam int cRcW = $clog2(pRepeatCnt + 1);
    localparam logic [cRcW-1:0] cRcLast = cRcW'(pRepeatCnt - 1);

    logic [cRcW-1:0] rcQ, rcD;
    logic            repeatQ, repeatD;

    // Repeat counter: counts held ticks in LONG, frozen in RCHK, cleared elsewhere.
    always_comb begin
      rcD     = rcQ;
      repeatD = 1'b0;
      if (iCke) begin
        if (stateQ == sLong && p) begin
          if (rcQ == cRcLast) begin
            rcD     = '0;
            repeatD = 1'b1;
          end else begin
            rcD = rcQ + 1'b1;
          end
        end else if (stateD != sLong && stateD != sRChk) begin
          rcD = '0;
        end
      end
    end

    // Repeat counter and pulse registers.
    always_ff @(posedge iSysClk or negedge iSysRst) begin
      if (!iSysRst) begin
        rcQ     <= '0;
        repeatQ <= 1'b0;
      end else begin
        rcQ     <= rcD;
        repeatQ <= repeatD;
      end
    end

    assign oRepeat[gCh] = repeatQ;
`else
    assign oRepeat[gCh] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// tb_key_debounce_ctrl
// Two channels, active-low pins, 4-tick debounce, 10-tick long press, 3-tick
// repeat, iCke every 5 clocks. A behavioural model predicts every output each
// cycle into a scoreboard queue that a negedge monitor pops and compares; the
// monitor also counts pulses for the directed per-step checks.
`timescale 1ns/1ps
module tb_key_debounce_ctrl;

  localparam int cCh     = 2;
  localparam int cStable = 4;
  localparam int cLong   = 10;
  localparam int cRepeat = 3;
`ifdef KEY_AUTO_REPEAT_EN
  localparam bit cRepOn = 1'b1;
`else
  localparam bit cRepOn = 1'b0;
`endif

  logic           iSysClk = 1'b0;
  logic           iSysRst;
  logic           iCke;
  logic [cCh-1:0] iKey;
  logic [cCh-1:0] oLevel, oPress, oRelease, oLong, oRepeat;
  logic [9:0]     outVec;

  key_debounce_ctrl #(
    .pChNum    (cCh),
    .pActiveLow(1),
    .pStableCnt(cStable),
    .pLongCnt  (cLong),
    .pRepeatCnt(cRepeat)
  ) dut (
    .iSysClk (iSysClk),
    .iSysRst (iSysRst),
    .iCke    (iCke),
    .iKey    (iKey),
    .oLevel  (oLevel),
    .oPress  (oPress),
    .oRelease(oRelease),
    .oLong   (oLong),
    .oRepeat (oRepeat)
  );

  always #5 iSysClk = ~iSysClk;

  assign outVec = {oLevel, oPress, oRelease, oLong, oRepeat};

  int checkCnt = 0;
  int errCnt   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    string      tag;
    logic [9:0] exp;
  } tSbEntry;

  tSbEntry expQ[$];
  tSbEntry monEnt;
  string   stepName;

  int pressCnt[cCh], relCnt[cCh], longCnt[cCh], rptCnt[cCh];
  int bothPressCnt, rel1OnlyCnt;
  int bPress[cCh], bRel[cCh], bLong[cCh], bRpt[cCh];
  int bBoth, bRel1Only;

  always @(negedge iSysClk) begin
    if (expQ.size() != 0) begin
      monEnt = expQ.pop_front();
      check(monEnt.tag, 32'(outVec), 32'(monEnt.exp));
    end
    for (int i = 0; i < cCh; i++) begin
      if (oPress[i])   pressCnt[i]++;
      if (oRelease[i]) relCnt[i]++;
      if (oLong[i])    longCnt[i]++;
      if (oRepeat[i])  rptCnt[i]++;
    end
    if (oPress == 2'b11)   bothPressCnt++;
    if (oRelease == 2'b10) rel1OnlyCnt++;
  end

  // ---------------- behavioural model ----------------
  // Per channel: run = consecutive samples disagreeing with the accepted level;
  // a sample that ends a run without acceptance is consumed by the abort.
  logic [cCh-1:0] mS1, mS2, mLevel;
  int             mRun[cCh], mHold[cCh], mRpt[cCh];
  bit             mLongDone[cCh];

  task automatic modelStep(output logic [9:0] expV);
    logic [cCh-1:0] p, pr, rl, lg, rp;
    pr = '0; rl = '0; lg = '0; rp = '0;
    if (!iSysRst) begin
      mS1 = '1; mS2 = '1; mLevel = '0;
      for (int c = 0; c < cCh; c++) begin
        mRun[c] = 0; mHold[c] = 0; mRpt[c] = 0; mLongDone[c] = 0;
      end
    end else begin
      p   = ~mS2;
      mS2 = mS1;
      mS1 = iKey;
      if (iCke) begin
        for (int c = 0; c < cCh; c++) begin
          if (p[c] != mLevel[c]) begin
            mRun[c]++;
            if (mRun[c] == cStable) begin
              mRun[c]   = 0;
              mLevel[c] = p[c];
              if (p[c]) pr[c] = 1'b1;
              else      rl[c] = 1'b1;
              mHold[c] = 0; mRpt[c] = 0; mLongDone[c] = 0;
            end
          end else if (mRun[c] != 0) begin
            mRun[c] = 0;
          end else if (mLevel[c]) begin
            if (!mLongDone[c]) begin
              mHold[c]++;
              if (mHold[c] == cLong) begin
                mLongDone[c] = 1; lg[c] = 1'b1;
              end
            end else if (cRepOn) begin
              mRpt[c]++;
              if (mRpt[c] == cRepeat) begin
                mRpt[c] = 0; rp[c] = 1'b1;
              end
            end
          end
        end
      end
    end
    expV = {mLevel, pr, rl, lg, rp};
  endtask

  // ---------------- stimulus ----------------
  task automatic doCycle(input logic cke);
    tSbEntry    ent;
    logic [9:0] e;
    iCke = cke;
    @(posedge iSysClk);
    modelStep(e);
    ent.tag = stepName;
    ent.exp = e;
    expQ.push_back(ent);
    @(negedge iSysClk);
  endtask

  // One sample period: key settles for 4 clocks, tick on the 5th.
  task automatic runTick(input logic [cCh-1:0] key);
    iKey = key;
    repeat (4) doCycle(1'b0);
    doCycle(1'b1);
    #1;
  endtask

  // iCke held high: sample every clock.
  task automatic runFast(input logic [cCh-1:0] key, input int n);
    iKey = key;
    repeat (n) doCycle(1'b1);
    #1;
  endtask

  task automatic snap();
    bPress = pressCnt; bRel = relCnt; bLong = longCnt; bRpt = rptCnt;
    bBoth = bothPressCnt; bRel1Only = rel1OnlyCnt;
  endtask

  initial begin
    iSysRst = 1'b1; iCke = 1'b0; iKey = 2'b11; stepName = "reset";
    #2 iSysRst = 1'b0;
    repeat (3) doCycle(1'b0);
    check("reset_outputs", 32'(outVec), 32'd0);
    iSysRst = 1'b1;

    // 1. clean press on channel 0, 20 ticks
    stepName = "t1_clean_press"; snap();
    repeat (3) runTick(2'b10);
    check("t1_no_press_before_4th", pressCnt[0] - bPress[0], 0);
    runTick(2'b10);
    check("t1_press_on_4th", pressCnt[0] - bPress[0], 1);
    check("t1_level_high", 32'(oLevel), 32'(2'b01));
    repeat (16) runTick(2'b10);
    check("t1_press_once", pressCnt[0] - bPress[0], 1);
    check("t1_long_once", longCnt[0] - bLong[0], 1);
    check("t1_no_release", relCnt[0] - bRel[0], 0);
    check("t1_repeats", rptCnt[0] - bRpt[0], cRepOn ? 2 : 0);
    stepName = "t1_release"; snap();
    repeat (6) runTick(2'b11);
    check("t1_release_once", relCnt[0] - bRel[0], 1);
    check("t1_level_low", 32'(oLevel), 32'd0);

    // 2. bounce: 3 low, 1 high, 4 low
    stepName = "t2_bounce"; snap();
    repeat (3) runTick(2'b10);
    runTick(2'b11);
    check("t2_no_press_after_bounce", pressCnt[0] - bPress[0], 0);
    repeat (3) runTick(2'b10);
    check("t2_no_press_3_of_4", pressCnt[0] - bPress[0], 0);
    runTick(2'b10);
    check("t2_single_press", pressCnt[0] - bPress[0], 1);

    // 3. long press: 16 ticks after oPress
    stepName = "t3_long"; snap();
    repeat (9) runTick(2'b10);
    check("t3_no_long_at_9", longCnt[0] - bLong[0], 0);
    runTick(2'b10);
    check("t3_long_at_10", longCnt[0] - bLong[0], 1);
    repeat (6) runTick(2'b10);
    check("t3_long_once", longCnt[0] - bLong[0], 1);
    check("t3_repeats", rptCnt[0] - bRpt[0], cRepOn ? 2 : 0);

    // 4. release glitch while in LONG
    stepName = "t4_glitch"; snap();
    repeat (2) runTick(2'b11);
    repeat (4) runTick(2'b10);
    check("t4_no_release", relCnt[0] - bRel[0], 0);
    check("t4_no_second_long", longCnt[0] - bLong[0], 0);
    check("t4_level_held", 32'(oLevel), 32'(2'b01));
    check("t4_repeat_resumes", rptCnt[0] - bRpt[0], cRepOn ? 1 : 0);
    stepName = "t4_release"; snap();
    repeat (6) runTick(2'b11);
    check("t4_release_once", relCnt[0] - bRel[0], 1);

    // 5. independence
    stepName = "t5_both_press"; snap();
    repeat (5) runTick(2'b00);
    check("t5_press_11_same_cycle", bothPressCnt - bBoth, 1);
    check("t5_press_ch1", pressCnt[1] - bPress[1], 1);
    stepName = "t5_release_ch1"; snap();
    repeat (5) runTick(2'b10);
    check("t5_release_10", rel1OnlyCnt - bRel1Only, 1);
    check("t5_ch0_no_release", relCnt[0] - bRel[0], 0);
    check("t5_level_01", 32'(oLevel), 32'(2'b01));

    // 6. async reset mid-hold, no clock edge
    #1;
    check("t6_pre_level", 32'(oLevel), 32'(2'b01));
    iSysRst = 1'b0;
    #1;
    check("t6_async_clear", 32'(outVec), 32'd0);
    @(negedge iSysClk);
    stepName = "t6_in_reset";
    repeat (2) doCycle(1'b0);
    iSysRst = 1'b1;
    stepName = "t6_repress"; snap();
    repeat (3) runTick(2'b10);
    check("t6_no_press_before_4th", pressCnt[0] - bPress[0], 0);
    runTick(2'b10);
    check("t6_press_after_reset", pressCnt[0] - bPress[0], 1);

    // iCke held high continuously
    stepName = "t7_cke_const"; snap();
    runFast(2'b11, 12);
    check("t7_release_ch0", relCnt[0] - bRel[0], 1);
    runFast(2'b01, 20);
    check("t7_press_ch1", pressCnt[1] - bPress[1], 1);
    check("t7_long_ch1", longCnt[1] - bLong[1], 1);
    runFast(2'b11, 12);
    check("t7_release_ch1", relCnt[1] - bRel[1], 1);
    check("t7_level_00", 32'(oLevel), 32'd0);

    @(negedge iSysClk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
    $finish;
  end

endmodule
